// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer and lock supervisor on the free-running reference clock.
// Sequences pll_rst, qualifies lock, gates the fabric reset and recovers on loss.
module pll_lock_supervisor #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3,
    parameter int SYNC_STAGES         = 2
) (
    input  logic       refclk,
    input  logic       rst,
    output logic       pll_rst,
    input  logic       pll_locked,
    input  logic       force_relock,
    output logic       sys_rst,
    output logic       status_ok,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [7:0] lock_lost_cnt
);

    localparam int MAX_AB = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                            RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_C  = (MAX_AB > LOCK_STABLE_CYCLES) ?
                            MAX_AB : LOCK_STABLE_CYCLES;
    localparam int TW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    localparam logic [TW-1:0] RST_LAST = TW'(RST_PULSE_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] ST_LAST  = TW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]    MAX_R    = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE_WAIT,
        RUNNING,
        FAILED
    } state_t;

    state_t            state, state_nx;
    logic [TW-1:0]     timer, timer_nx;
    logic [3:0]        retry_nx;
    logic [7:0]        lost_nx;
    logic [SYNC_STAGES-1:0] sync_q;
    logic              lk;

    assign lk = sync_q[SYNC_STAGES-1];

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    always_comb begin
        state_nx = state;
        timer_nx = timer;
        retry_nx = retry_cnt;
        lost_nx  = lock_lost_cnt;
        if (force_relock) begin
            state_nx = RESET_PLL;
            retry_nx = '0;
        end else begin
            unique case (state)
                RESET_PLL: begin
                    timer_nx = timer + 1'b1;
                    if (timer == RST_LAST) state_nx = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    timer_nx = timer + 1'b1;
                    if (lk) begin
                        state_nx = STABLE_WAIT;
                    end else if (timer == TO_LAST) begin
                        retry_nx = (retry_cnt == 4'hf) ? retry_cnt : retry_cnt + 4'd1;
                        state_nx = (retry_nx >= MAX_R) ? FAILED : RESET_PLL;
                    end
                end
                STABLE_WAIT: begin
                    timer_nx = timer + 1'b1;
                    if (!lk) begin
                        state_nx = WAIT_LOCK;
                    end else if (timer == ST_LAST) begin
                        state_nx = RUNNING;
                        retry_nx = '0;
                    end
                end
                RUNNING: begin
                    if (!lk) begin
                        state_nx = RESET_PLL;
                        lost_nx  = (lock_lost_cnt == 8'hff) ? lock_lost_cnt
                                                            : lock_lost_cnt + 8'd1;
                    end
                end
                FAILED: begin
                    state_nx = FAILED;
                end
                default: begin
                    state_nx = RESET_PLL;
                end
            endcase
        end
        // A forced relock restarts the pulse even when already in RESET_PLL.
        if (force_relock || state_nx != state) timer_nx = '0;
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state         <= RESET_PLL;
            timer         <= '0;
            retry_cnt     <= '0;
            lock_lost_cnt <= '0;
            pll_rst       <= 1'b1;
            sys_rst       <= 1'b1;
            status_ok     <= 1'b0;
            fail          <= 1'b0;
        end else begin
            state         <= state_nx;
            timer         <= timer_nx;
            retry_cnt     <= retry_nx;
            lock_lost_cnt <= lost_nx;
            pll_rst       <= (state_nx == RESET_PLL) || (state_nx == FAILED);
            sys_rst       <= (state_nx != RUNNING);
            status_ok     <= (state_nx == RUNNING);
            fail          <= (state_nx == FAILED);
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: vector table plus
// hand-written multi-cycle sequences for loss, glitch, force and reset.
module tb_pll_lock_supervisor;

    localparam int P  = 4;
    localparam int T  = 20;
    localparam int S  = 8;
    localparam int MR = 2;
    localparam int SY = 2;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       force_relock = 1'b0;
    logic       pll_rst, sys_rst, status_ok, fail;
    logic [3:0] retry_cnt;
    logic [7:0] lock_lost_cnt;

    int nerr = 0;
    int nchk = 0;

    pll_lock_supervisor #(
        .RST_PULSE_CYCLES    (P),
        .LOCK_TIMEOUT_CYCLES (T),
        .LOCK_STABLE_CYCLES  (S),
        .MAX_RETRIES         (MR),
        .SYNC_STAGES         (SY)
    ) dut (
        .refclk        (refclk),
        .rst           (rst),
        .pll_rst       (pll_rst),
        .pll_locked    (pll_locked),
        .force_relock  (force_relock),
        .sys_rst       (sys_rst),
        .status_ok     (status_ok),
        .fail          (fail),
        .retry_cnt     (retry_cnt),
        .lock_lost_cnt (lock_lost_cnt)
    );

    always #10 refclk = ~refclk;

    typedef struct {
        logic r;
        logic lk;
        logic fr;
        int   n;
        logic e_pr;
        logic e_sr;
        logic e_ok;
        logic e_fl;
        int   e_rc;
        int   e_lc;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(input logic r, input logic lk, input logic fr,
                                input int n, input logic pr, input logic sr,
                                input logic ok, input logic fl,
                                input int rc, input int lc);
        vec_t v;
        v.r = r; v.lk = lk; v.fr = fr; v.n = n;
        v.e_pr = pr; v.e_sr = sr; v.e_ok = ok; v.e_fl = fl;
        v.e_rc = rc; v.e_lc = lc;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int pr, input int sr,
                           input int ok, input int fl, input int rc, input int lc);
        chk({tag, "_pll_rst"}, int'(pll_rst), pr);
        chk({tag, "_sys_rst"}, int'(sys_rst), sr);
        chk({tag, "_status_ok"}, int'(status_ok), ok);
        chk({tag, "_fail"}, int'(fail), fl);
        chk({tag, "_retry_cnt"}, int'(retry_cnt), rc);
        chk({tag, "_lock_lost_cnt"}, int'(lock_lost_cnt), lc);
    endtask

    task automatic wait_ok(output int c);
        c = 0;
        while (!status_ok && c < 200) begin
            @(posedge refclk);
            @(negedge refclk);
            c++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int okcnt;

        // Power-up lock, then permanent no-lock into FAILED, then forced recovery.
        tbl[0]  = mk(1, 1, 0, 0,  1, 1, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 0, 3,  1, 1, 0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 0, 1,  0, 1, 0, 0, 0, 0);
        tbl[3]  = mk(0, 1, 0, 8,  0, 1, 0, 0, 0, 0);
        tbl[4]  = mk(0, 1, 0, 1,  0, 0, 1, 0, 0, 0);
        tbl[5]  = mk(1, 0, 0, 0,  1, 1, 0, 0, 0, 0);
        tbl[6]  = mk(0, 0, 0, 4,  0, 1, 0, 0, 0, 0);
        tbl[7]  = mk(0, 0, 0, 19, 0, 1, 0, 0, 0, 0);
        tbl[8]  = mk(0, 0, 0, 1,  1, 1, 0, 0, 1, 0);
        tbl[9]  = mk(0, 0, 0, 4,  0, 1, 0, 0, 1, 0);
        tbl[10] = mk(0, 0, 0, 19, 0, 1, 0, 0, 1, 0);
        tbl[11] = mk(0, 0, 0, 1,  1, 1, 0, 1, 2, 0);
        tbl[12] = mk(0, 1, 0, 30, 1, 1, 0, 1, 2, 0);
        tbl[13] = mk(0, 1, 1, 1,  1, 1, 0, 0, 0, 0);
        tbl[14] = mk(0, 1, 0, 3,  1, 1, 0, 0, 0, 0);
        tbl[15] = mk(0, 1, 0, 1,  0, 1, 0, 0, 0, 0);
        tbl[16] = mk(0, 1, 0, 1,  0, 1, 0, 0, 0, 0);
        tbl[17] = mk(0, 1, 0, 8,  0, 0, 1, 0, 0, 0);

        @(negedge refclk);
        for (int i = 0; i < 18; i++) begin
            rst          = tbl[i].r;
            pll_locked   = tbl[i].lk;
            force_relock = tbl[i].fr;
            if (tbl[i].n == 0) begin
                #1;
            end else begin
                repeat (tbl[i].n) @(posedge refclk);
                @(negedge refclk);
            end
            chk_all($sformatf("v%0d", i), int'(tbl[i].e_pr), int'(tbl[i].e_sr),
                    int'(tbl[i].e_ok), int'(tbl[i].e_fl), tbl[i].e_rc, tbl[i].e_lc);
        end
        force_relock = 1'b0;

        // One-cycle lock drop in RUNNING.
        pll_locked = 1'b0;
        @(posedge refclk);
        c = 1;
        @(negedge refclk);
        pll_locked = 1'b1;
        while (!sys_rst && c < 10) begin
            @(posedge refclk);
            @(negedge refclk);
            c++;
        end
        chk("loss_latency", c, SY + 1);
        chk("loss_pll_rst", int'(pll_rst), 1);
        chk("loss_cnt", int'(lock_lost_cnt), 1);
        wait_ok(c);
        chk("relock_cycles", c, P + 1 + S);
        chk_all("relock", 0, 0, 1, 0, 0, 1);

        // force_relock on the cycle the synced lock fall reaches the FSM.
        @(negedge refclk);
        pll_locked = 1'b0;
        @(posedge refclk);
        @(negedge refclk);
        @(posedge refclk);
        @(negedge refclk);
        force_relock = 1'b1;
        @(posedge refclk);
        @(negedge refclk);
        force_relock = 1'b0;
        pll_locked   = 1'b1;
        chk_all("force_run", 1, 1, 0, 0, 0, 1);
        wait_ok(c);
        chk("force_run_relock", int'(status_ok), 1);

        // Lock glitch at stable cycle 5 restarts qualification.
        rst = 1'b1;
        #1;
        @(negedge refclk);
        rst = 1'b0;
        repeat (8) @(posedge refclk);
        @(negedge refclk);
        pll_locked = 1'b0;
        @(posedge refclk);
        @(negedge refclk);
        pll_locked = 1'b1;
        c = 9;
        while (!status_ok && c < 100) begin
            @(posedge refclk);
            @(negedge refclk);
            c++;
        end
        chk("glitch_rise_edge", c, 20);
        chk("glitch_retry", int'(retry_cnt), 0);

        // Async reset in WAIT_LOCK after one retry.
        rst = 1'b1;
        pll_locked = 1'b0;
        #1;
        @(negedge refclk);
        rst = 1'b0;
        repeat (30) @(posedge refclk);
        #3;
        chk("pre_rst_wait_pll_rst", int'(pll_rst), 0);
        chk("pre_rst_wait_retry", int'(retry_cnt), 1);
        rst = 1'b1;
        #1;
        chk_all("rst_wait", 1, 1, 0, 0, 0, 0);

        // 300 lock losses saturate the loss counter.
        @(negedge refclk);
        rst = 1'b0;
        pll_locked = 1'b1;
        okcnt = 0;
        for (int k = 0; k < 300; k++) begin
            wait_ok(c);
            if (status_ok) okcnt++;
            pll_locked = 1'b0;
            c = 0;
            while (!sys_rst && c < 10) begin
                @(posedge refclk);
                @(negedge refclk);
                c++;
            end
            pll_locked = 1'b1;
        end
        chk("loss_loop_runs", okcnt, 300);
        chk("loss_saturate", int'(lock_lost_cnt), 255);

        // Async reset in RUNNING clears everything.
        wait_ok(c);
        chk("pre_rst_run_ok", int'(status_ok), 1);
        @(posedge refclk);
        #3;
        rst = 1'b1;
        #1;
        chk_all("rst_run", 1, 1, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
